// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per clock, start/busy/done handshake.
// Latency: done pulses WIDTH+1 cycles after start is accepted; start is ignored while busy.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 overflow_q, overflow_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_shift;

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        overflow_d = overflow_q;

        // The carry out of the high-half add is kept as bit WIDTH of sum so the
        // shift brings it into the top of the accumulator instead of losing it.
        if (acc_q[0]) begin
            sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end else begin
            sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end
        acc_shift = {sum, acc_q[WIDTH-1:1]};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mcand_d = multiplicand;
                    acc_d   = {{WIDTH{1'b0}}, multiplier};
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = acc_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    product_d  = acc_shift;
                    overflow_d = |acc_shift[2*WIDTH-1:WIDTH];
                    state_d    = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mcand_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign product  = product_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised self-checking bench for seq_multiplier against a cycle-timeline reference model.
module tb_seq_multiplier;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           overflow;

    int n_chk = 0;
    int n_fail = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start yields A*B after W busy cycles.
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_pend = '0;
    bit             m_busy = 1'b0;
    bit             m_done = 1'b0;
    int             m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prod = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_prod = m_pend;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_pend = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                m_busy = 1'b1;
                m_left = W;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
        chk("cyc_done", {63'd0, done}, {63'd0, m_done});
        chk("cyc_product", product, m_prod);
        chk("cyc_overflow", {63'd0, overflow}, {63'd0, (m_prod[2*W-1:W] != '0)});
        if (busy && done) begin
            chk("busy_and_done", {63'd0, done}, 64'd0);
        end
    end

    // Called at a negedge; returns at the negedge where done is seen high.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [2*W-1:0] p, output int lat, output int busy_n);
        int k;
        start = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        k = 0;
        busy_n = 0;
        while (!done && k < 100) begin
            busy_n += int'(busy);
            @(negedge clk);
            k++;
        end
        chk("done_timeout", {63'd0, done}, 64'd1);
        lat = k + 1;
        p = product;
    endtask

    initial begin
        logic [2*W-1:0] p;
        logic [W-1:0]   x, y;
        int             lat, bn, k;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        repeat (10) @(negedge clk);
        chk("idle_product", product, 64'd0);

        do_op(32'd7, 32'd6, p, lat, bn);
        chk("p7x6", p, 64'd42);
        chk("p7x6_ovf", {63'd0, overflow}, 64'd0);
        chk("p7x6_latency", 64'(lat), 64'd33);
        chk("p7x6_busy_cycles", 64'(bn), 64'd32);
        @(negedge clk);
        chk("done_single_pulse", {63'd0, done}, 64'd0);
        repeat (20) @(negedge clk);
        chk("p7x6_hold", product, 64'd42);

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat, bn);
        chk("pmax", p, 64'hFFFF_FFFE_0000_0001);
        chk("pmax_ovf", {63'd0, overflow}, 64'd1);
        @(negedge clk);
        do_op(32'h0001_0000, 32'h0001_0000, p, lat, bn);
        chk("p2_32", p, 64'h0000_0001_0000_0000);
        chk("p2_32_ovf", {63'd0, overflow}, 64'd1);
        @(negedge clk);

        do_op(32'h1234_5678, 32'd0, p, lat, bn);
        chk("pzero_b", p, 64'd0);
        chk("pzero_b_ovf", {63'd0, overflow}, 64'd0);
        chk("pzero_b_latency", 64'(lat), 64'd33);
        @(negedge clk);
        do_op(32'd0, 32'hDEAD_BEEF, p, lat, bn);
        chk("pzero_a", p, 64'd0);
        chk("pzero_a_latency", 64'(lat), 64'd33);
        @(negedge clk);

        start = 1'b1;
        a = 32'd3;
        b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        a = 32'd100;
        b = 32'd100;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ign_done_timeout", {63'd0, done}, 64'd1);
        chk("ignored_start", product, 64'd15);
        start = 1'b1;
        a = 32'd9;
        b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_gap", 64'(k), 64'd33);
        chk("b2b_product", product, 64'd81);
        @(negedge clk);

        start = 1'b1;
        a = 32'd1000;
        b = 32'd1000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_product", product, 64'd0);
        chk("abort_overflow", {63'd0, overflow}, 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_done", {63'd0, done}, 64'd0);
        do_op(32'd1000, 32'd1000, p, lat, bn);
        chk("p1000sq", p, 64'd1000000);
        chk("p1000sq_latency", 64'(lat), 64'd33);
        @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 4 == 0) y = W'($urandom_range(0, 255));
            if (i % 7 == 0) x = W'($urandom_range(0, 65535));
            do_op(x, y, p, lat, bn);
            chk("rand_product", p, {{W{1'b0}}, x} * {{W{1'b0}}, y});
            chk("rand_latency", 64'(lat), 64'd33);
            if (i % 2 == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
